sa_frame_streamer: RTL and testbench
====================================

// Module: sa_frame_streamer
// PURPOSE
//  Consumer end of the toggle-strobed SA-rate data interface. It detects each
//  saToggle transition and captures the parallel multi-channel word. The captured
//  frame is then serialized onto an AXI-Stream-style master, one channel per beat,
//  for readout or packetization. It sits downstream of the SA decimator, on the
//  same clock, and absorbs back-pressure with one pending-frame buffer plus
//  overrun accounting.
// PARAMETERS
//  DATA_WIDTH     32  bits per channel word
//  CHANNEL_COUNT  4   channels per frame (>=2)
//  SEQ_WIDTH      16  width of per-frame sequence number
// PORTS
//  clk            in   1                     system clock
//  rst_n          in   1                     asynchronous active-low reset
//  saToggle       in   1                     inverts once per new SA frame (same clk domain)
//  saData         in   CHANNEL_COUNT*DATA_WIDTH  frame, ch i at [i*DATA_WIDTH+:DATA_WIDTH]
//  M_TDATA        out  DATA_WIDTH            current channel word
//  M_TVALID       out  1                     beat valid
//  M_TREADY       in   1                     downstream ready
//  M_TLAST        out  1                     high on beat of channel CHANNEL_COUNT-1
//  M_TUSER        out  clog2(CHANNEL_COUNT)  channel index of current beat
//  M_SEQ          out  SEQ_WIDTH             sequence number of frame being sent
//  overrunCount   out  16                    frames dropped, saturating at 16'hFFFF
//  overrunClear   in   1                     synchronous clear of overrunCount
// BEHAVIOUR
//  - Reset (async assert, sync release): M_TVALID=0, M_TDATA=0, M_TLAST=0,
//    M_TUSER=0, M_SEQ=0, overrunCount=0, toggleMatch=0, pendingValid=0, state IDLE.
//  - Event: saToggle != toggleMatch at a clk edge. At that edge, toggleMatch<=saToggle
//    and saData is captured. Exactly one event per transition; a static level is no event.
//  - Sequence: seqNext starts at 0 and increments (wraps) on every ACCEPTED frame.
//    Each frame carries the value assigned at capture. A dropped frame consumes no number.
//  - FSM IDLE: on event, shadow<=saData, M_SEQ<=seqNext, idx<=0, M_TVALID<=1 -> SEND.
//    Latency: beat 0 is valid in the cycle after the capturing edge.
//  - FSM SEND: M_TDATA=shadow[idx], M_TUSER=idx, M_TLAST=(idx==CHANNEL_COUNT-1).
//    Beat is transferred when M_TVALID&M_TREADY. On a non-last beat, idx++.
//    M_TDATA/M_TUSER/M_TLAST/M_SEQ stay stable while M_TVALID&!M_TREADY.
//  - Event in SEND: if !pendingValid, pending<=saData and pendingValid<=1 (its seq is
//    reserved at that edge). If pendingValid is already set, the new frame is dropped
//    and overrunCount++ (saturating).
//  - Last beat transferred: if pendingValid, load shadow from pending, clear pendingValid,
//    idx<=0, stay in SEND (back-to-back, no bubble). Else if an event occurs the same
//    edge, load shadow directly from saData and stay in SEND. Else M_TVALID<=0 -> IDLE.
//    If pendingValid and an event occur together: pending->shadow, saData->pending,
//    no drop.
//  - overrunClear and an overrun on the same edge: clear wins, count=0.
//  - Reset mid-frame: beat in flight and pending frame are discarded, and nothing
//    resumes after release.
// TESTING
//  - Reset, saToggle=0 static 100 cycles -> M_TVALID never asserts, overrunCount=0.
//  - CHANNEL_COUNT=4, toggle with saData={D3,D2,D1,D0}, M_TREADY=1 -> M_TVALID from next
//    cycle. Beats D0..D3 arrive on 4 consecutive cycles, TUSER 0..3, TLAST on D3 only,
//    M_SEQ=0.
//  - M_TREADY=0 for 10 cycles, 3 toggles (frames A,B,C) -> A sent, B pending, C dropped,
//    overrunCount=1. After ready, A then B back-to-back with M_SEQ=0,1; next frame gets 2.
//  - Toggle on the same edge as A's TLAST handshake, no pending -> next frame's beat 0
//    is on the following cycle with no idle gap.
//  - overrunCount forced to 16'hFFFF by repeated drops -> holds at 16'hFFFF.
//    overrunClear with a simultaneous drop -> 0.
//  - rst_n low during beat 2 with a pending frame -> M_TVALID=0 immediately.
//    After release, the next toggle yields M_SEQ=0.

Source files
------------

// File: rtl/sa_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module     : sa_frame_streamer
// Description: Captures toggle-strobed SA frames and serializes them onto an
//              AXI-Stream master, one channel per beat, with one pending slot.
// Revision   : 1.0 - initial release
// ============================================================================
module sa_frame_streamer #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNEL_COUNT = 4,
  parameter int SEQ_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                saToggle,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] saData,
  output logic [DATA_WIDTH-1:0]               M_TDATA,
  output logic                                M_TVALID,
  input  logic                                M_TREADY,
  output logic                                M_TLAST,
  output logic [$clog2(CHANNEL_COUNT)-1:0]    M_TUSER,
  output logic [SEQ_WIDTH-1:0]                M_SEQ,
  output logic [15:0]                         overrunCount,
  input  logic                                overrunClear
);

  localparam int                  c_idxWidth   = $clog2(CHANNEL_COUNT);
  localparam int                  c_frameWidth = CHANNEL_COUNT * DATA_WIDTH;
  localparam logic [c_idxWidth-1:0] c_lastIdx  = c_idxWidth'(CHANNEL_COUNT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  logic                    r_toggleMatch;
  logic [c_frameWidth-1:0] r_shadow;
  logic [c_frameWidth-1:0] r_pending;
  logic [SEQ_WIDTH-1:0]    r_pendingSeq;
  logic                    r_pendingValid;
  logic [SEQ_WIDTH-1:0]    r_seqNext;

  logic                    w_event;
  logic                    w_xfer;
  logic                    w_lastXfer;
  logic                    w_drop;
  logic [c_idxWidth-1:0]   w_nextIdx;
  logic [DATA_WIDTH-1:0]   w_nextWord;

  assign w_event    = saToggle ^ r_toggleMatch;
  assign w_xfer     = M_TVALID & M_TREADY;
  assign w_lastXfer = w_xfer & M_TLAST;
  assign w_nextIdx  = M_TUSER + 1'b1;
  // A frame is dropped only when the pending slot is full and cannot drain this edge.
  assign w_drop     = w_event && (r_state == ST_SEND) && r_pendingValid && !w_lastXfer;

  always_comb begin
    w_nextWord = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (w_nextIdx == c_idxWidth'(i)) w_nextWord = r_shadow[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_toggleMatch  <= 1'b0;
      r_shadow       <= '0;
      r_pending      <= '0;
      r_pendingSeq   <= '0;
      r_pendingValid <= 1'b0;
      r_seqNext      <= '0;
      M_TDATA        <= '0;
      M_TVALID       <= 1'b0;
      M_TLAST        <= 1'b0;
      M_TUSER        <= '0;
      M_SEQ          <= '0;
      overrunCount   <= '0;
    end else begin
      r_toggleMatch <= saToggle;

      if (overrunClear)
        overrunCount <= '0;
      else if (w_drop && overrunCount != 16'hFFFF)
        overrunCount <= overrunCount + 16'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_shadow  <= saData;
            M_TDATA   <= saData[DATA_WIDTH-1:0];
            M_TUSER   <= '0;
            M_TLAST   <= 1'b0;
            M_SEQ     <= r_seqNext;
            r_seqNext <= r_seqNext + 1'b1;
            M_TVALID  <= 1'b1;
            r_state   <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (w_xfer && !M_TLAST) begin
            M_TUSER <= w_nextIdx;
            M_TDATA <= w_nextWord;
            M_TLAST <= (w_nextIdx == c_lastIdx);
          end

          if (w_lastXfer) begin
            if (r_pendingValid) begin
              r_shadow <= r_pending;
              M_TDATA  <= r_pending[DATA_WIDTH-1:0];
              M_TUSER  <= '0;
              M_TLAST  <= 1'b0;
              M_SEQ    <= r_pendingSeq;
              if (w_event) begin
                r_pending    <= saData;
                r_pendingSeq <= r_seqNext;
                r_seqNext    <= r_seqNext + 1'b1;
              end else begin
                r_pendingValid <= 1'b0;
              end
            end else if (w_event) begin
              r_shadow  <= saData;
              M_TDATA   <= saData[DATA_WIDTH-1:0];
              M_TUSER   <= '0;
              M_TLAST   <= 1'b0;
              M_SEQ     <= r_seqNext;
              r_seqNext <= r_seqNext + 1'b1;
            end else begin
              M_TVALID <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else if (w_event && !r_pendingValid) begin
            r_pending      <= saData;
            r_pendingSeq   <= r_seqNext;
            r_pendingValid <= 1'b1;
            r_seqNext      <= r_seqNext + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module     : tb_sa_frame_streamer
// Description: Directed self-checking bench for sa_frame_streamer.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sa_frame_streamer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         saToggle = 1'b0;
  logic [127:0] saData = '0;
  logic [31:0]  M_TDATA;
  logic         M_TVALID;
  logic         M_TREADY = 1'b0;
  logic         M_TLAST;
  logic [1:0]   M_TUSER;
  logic [15:0]  M_SEQ;
  logic [15:0]  overrunCount;
  logic         overrunClear = 1'b0;

  int checks = 0;
  int failures = 0;

  sa_frame_streamer #(.DATA_WIDTH(32), .CHANNEL_COUNT(4), .SEQ_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .saToggle     (saToggle),
    .saData       (saData),
    .M_TDATA      (M_TDATA),
    .M_TVALID     (M_TVALID),
    .M_TREADY     (M_TREADY),
    .M_TLAST      (M_TLAST),
    .M_TUSER      (M_TUSER),
    .M_SEQ        (M_SEQ),
    .overrunCount (overrunCount),
    .overrunClear (overrunClear)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mkFrame(input logic [31:0] base);
    mkFrame = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    saToggle = 1'b0;
    M_TREADY = 1'b0;
    overrunClear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    bit sawValid;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA, overrunCount} !== 68'd0) begin
      failures++;
      $display("FAIL reset_values got=%h want=0", {M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA, overrunCount});
    end
    rst_n = 1'b1;
    M_TREADY = 1'b1;
    sawValid = 1'b0;
    repeat (100) begin
      tick();
      if (M_TVALID !== 1'b0) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      failures++;
      $display("FAIL reset_static_tvalid got=1 want=0");
    end
    checks++;
    if (overrunCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_static_overrun got=%h want=0000", overrunCount);
    end
  endtask

  task automatic test_basic;
    logic [51:0] exp;
    do_reset();
    M_TREADY = 1'b1;
    saData = mkFrame(32'hA000_0000);
    saToggle = ~saToggle;
    checks++;
    if (M_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_prelatency got=%b want=0", M_TVALID);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, (k == 3), 2'(k), 16'd0, 32'hA000_0000 + 32'(k)};
      checks++;
      if ({M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA} !== exp) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h want=%h", k, {M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA}, exp);
      end
      tick();
    end
    checks++;
    if (M_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL basic_end_tvalid got=%b want=0", M_TVALID);
    end
  endtask

  task automatic test_backpressure;
    logic [51:0] exp;
    logic [31:0] base;
    do_reset();
    M_TREADY = 1'b0;
    saData = mkFrame(32'h1000_0000); saToggle = ~saToggle; tick();
    saData = mkFrame(32'h2000_0000); saToggle = ~saToggle; tick();
    saData = mkFrame(32'h3000_0000); saToggle = ~saToggle; tick();
    saData = mkFrame(32'h4444_0000);
    repeat (7) tick();
    checks++;
    if ({M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA} !== {1'b1, 1'b0, 2'd0, 16'd0, 32'h1000_0000}) begin
      failures++;
      $display("FAIL bp_stall_hold got=%h want=%h", {M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA},
               {1'b1, 1'b0, 2'd0, 16'd0, 32'h1000_0000});
    end
    checks++;
    if (overrunCount !== 16'd1) begin
      failures++;
      $display("FAIL bp_overrun got=%h want=0001", overrunCount);
    end
    M_TREADY = 1'b1;
    for (int f = 0; f < 8; f++) begin
      base = (f < 4) ? 32'h1000_0000 : 32'h2000_0000;
      exp = {1'b1, (f % 4 == 3), 2'(f % 4), 16'(f / 4), base + 32'(f % 4)};
      checks++;
      if ({M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA} !== exp) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h want=%h", f, {M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA}, exp);
      end
      tick();
    end
    checks++;
    if (M_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%b want=0", M_TVALID);
    end
    saData = mkFrame(32'h5000_0000);
    saToggle = ~saToggle;
    tick();
    checks++;
    if ({M_TVALID, M_SEQ, M_TDATA} !== {1'b1, 16'd2, 32'h5000_0000}) begin
      failures++;
      $display("FAIL bp_next_seq got=%h want=%h", {M_TVALID, M_SEQ, M_TDATA}, {1'b1, 16'd2, 32'h5000_0000});
    end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    M_TREADY = 1'b1;
    saData = mkFrame(32'h6000_0000);
    saToggle = ~saToggle;
    tick();
    repeat (3) tick();
    checks++;
    if ({M_TVALID, M_TLAST, M_TDATA} !== {1'b1, 1'b1, 32'h6000_0003}) begin
      failures++;
      $display("FAIL b2b_last_beat got=%h want=%h", {M_TVALID, M_TLAST, M_TDATA}, {1'b1, 1'b1, 32'h6000_0003});
    end
    saData = mkFrame(32'h7000_0000);
    saToggle = ~saToggle;
    tick();
    checks++;
    if ({M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA} !== {1'b1, 1'b0, 2'd0, 16'd1, 32'h7000_0000}) begin
      failures++;
      $display("FAIL b2b_no_gap got=%h want=%h", {M_TVALID, M_TLAST, M_TUSER, M_SEQ, M_TDATA},
               {1'b1, 1'b0, 2'd0, 16'd1, 32'h7000_0000});
    end
    repeat (4) tick();
    checks++;
    if (M_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end_tvalid got=%b want=0", M_TVALID);
    end
  endtask

  task automatic test_overrun_saturate;
    do_reset();
    M_TREADY = 1'b0;
    saData = mkFrame(32'h8000_0000);
    repeat (65542) begin
      saToggle = ~saToggle;
      tick();
    end
    checks++;
    if (overrunCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h want=ffff", overrunCount);
    end
    overrunClear = 1'b1;
    saToggle = ~saToggle;
    tick();
    overrunClear = 1'b0;
    checks++;
    if (overrunCount !== 16'd0) begin
      failures++;
      $display("FAIL sat_clear_wins got=%h want=0000", overrunCount);
    end
    saToggle = ~saToggle;
    tick();
    checks++;
    if (overrunCount !== 16'd1) begin
      failures++;
      $display("FAIL sat_after_clear got=%h want=0001", overrunCount);
    end
  endtask

  task automatic test_reset_midframe;
    bit sawValid;
    do_reset();
    M_TREADY = 1'b1;
    saData = mkFrame(32'h9000_0000); saToggle = ~saToggle; tick();
    tick();
    saData = mkFrame(32'hB000_0000); saToggle = ~saToggle; tick();
    checks++;
    if ({M_TVALID, M_TUSER, M_TDATA} !== {1'b1, 2'd2, 32'h9000_0002}) begin
      failures++;
      $display("FAIL mid_beat2 got=%h want=%h", {M_TVALID, M_TUSER, M_TDATA}, {1'b1, 2'd2, 32'h9000_0002});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (M_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_clear got=%b want=0", M_TVALID);
    end
    saToggle = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (5) begin
      tick();
      if (M_TVALID !== 1'b0) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      failures++;
      $display("FAIL mid_no_resume got=1 want=0");
    end
    saData = mkFrame(32'hC000_0000);
    saToggle = ~saToggle;
    tick();
    checks++;
    if ({M_TVALID, M_TUSER, M_SEQ, M_TDATA} !== {1'b1, 2'd0, 16'd0, 32'hC000_0000}) begin
      failures++;
      $display("FAIL mid_restart got=%h want=%h", {M_TVALID, M_TUSER, M_SEQ, M_TDATA},
               {1'b1, 2'd0, 16'd0, 32'hC000_0000});
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun_saturate();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
